// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: shared mode encoding, pipeline latency and saturation helper
// for the DSP MAC slice.
package dsp_mac_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SUM   = 2'b00;
    localparam mode_t MODE_ACC   = 2'b01;
    localparam mode_t MODE_CHAIN = 2'b10;
    localparam mode_t MODE_RSVD  = 2'b11;

    // Edges from in_valid capture to out_valid.
    localparam int unsigned DSP_MAC_LAT = 4;

    // Widest accumulator the saturation helper can describe.
    localparam int unsigned SAT_MAX_W = 128;

    // Signed max (neg=0) or min (neg=1) of a w-bit word, in the low w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_bound(input int unsigned w, input logic neg);
        logic [SAT_MAX_W-1:0] hi_ones;
        hi_ones = {SAT_MAX_W{1'b1}} << (w - 1);
        return neg ? hi_ones : ~hi_ones;
    endfunction

endpackage

// File: rtl/dsp_mac_slice_if.sv
// dsp_mac_slice_if: operand/control bus into the slice and result bus out.
// master = upstream driver, slave = the slice.
interface dsp_mac_slice_if
    import dsp_mac_pkg::*;
#(
    parameter int unsigned A_W     = 18,
    parameter int unsigned B_W     = 18,
    parameter int unsigned N_PAIRS = 4,
    parameter int unsigned ACC_W   = 64,
    parameter int unsigned CHAIN_W = 44
);
    logic                     in_valid;
    logic [N_PAIRS*A_W-1:0]   a_bus;
    logic [N_PAIRS*B_W-1:0]   b_bus;
    mode_t                    mode;
    logic                     acc_load;
    logic [CHAIN_W-1:0]       from_previous;
    logic                     out_valid;
    logic [ACC_W-1:0]         result;
    logic [CHAIN_W-1:0]       to_next;
    logic                     overflow;

    modport master (
        output in_valid, a_bus, b_bus, mode, acc_load, from_previous,
        input  out_valid, result, to_next, overflow
    );

    modport slave (
        input  in_valid, a_bus, b_bus, mode, acc_load, from_previous,
        output out_valid, result, to_next, overflow
    );
endinterface

// File: rtl/dsp_mult_lane.sv
// dsp_mult_lane: one registered signed A_W x B_W multiplier, product
// sign-extended to ACC_W.
module dsp_mult_lane #(
    parameter int unsigned A_W   = 18,
    parameter int unsigned B_W   = 18,
    parameter int unsigned ACC_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic [ACC_W-1:0] p_o
);
    localparam int unsigned P_W = A_W + B_W;

    logic signed [P_W-1:0] prod_c;
    logic [ACC_W-1:0]      p_d;
    logic [ACC_W-1:0]      p_q;

    // Full-precision signed product, then sign extension to accumulator width.
    always_comb begin
        prod_c = P_W'($signed(a_i)) * P_W'($signed(b_i));
        p_d    = ACC_W'(prod_c);
    end

    // Product register, loaded only for valid beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: N_PAIRS signed multipliers, registered adder tree and
// SUM/ACC/CHAIN result stage with sticky overflow and cascade output.
// Optional build macro: DSP_MAC_SATURATE_EN (clamp overflowing additions).
module dsp_mac_slice
    import dsp_mac_pkg::*;
#(
    parameter int unsigned A_W     = 18,
    parameter int unsigned B_W     = 18,
    parameter int unsigned N_PAIRS = 4,
    parameter int unsigned ACC_W   = 64,
    parameter int unsigned CHAIN_W = 44
) (
    input  logic           clk,
    input  logic           reset,
    dsp_mac_slice_if.slave bus
);
    localparam int unsigned LAT = DSP_MAC_LAT;
    localparam int unsigned LVL = $clog2(N_PAIRS);
    localparam int unsigned NP2 = 1 << LVL;

    // Valid shift: [0]=S1 .. [LAT-1]=S4/out_valid.
    logic [LAT-1:0] vld_q;

    logic [N_PAIRS*A_W-1:0] a1_q;
    logic [N_PAIRS*B_W-1:0] b1_q;
    mode_t                  mode1_q, mode2_q, mode3_q;
    logic                   load1_q, load2_q, load3_q;
    logic [CHAIN_W-1:0]     prev1_q, prev2_q, prev3_q;

    logic [ACC_W-1:0] prod [N_PAIRS];
    logic [ACC_W-1:0] tree [LVL+1][NP2];
    logic [ACC_W-1:0] sum3_q;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic [CHAIN_W-1:0] to_next_q, to_next_d;
    logic               ov_q, ov_d;

    logic [ACC_W-1:0] add_a, add_b, add_s, val, prev_ext;
    logic             do_add, add_ovf;

    // Valid pipeline and S1 capture of operands plus control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            mode1_q <= MODE_SUM;
            load1_q <= 1'b0;
            prev1_q <= '0;
        end else begin
            vld_q <= {vld_q[LAT-2:0], bus.in_valid};
            if (bus.in_valid) begin
                a1_q    <= bus.a_bus;
                b1_q    <= bus.b_bus;
                mode1_q <= bus.mode;
                load1_q <= bus.acc_load;
                prev1_q <= bus.from_previous;
            end
        end
    end

    // S2: one registered multiplier per lane.
    for (genvar i = 0; i < N_PAIRS; i++) begin : g_lane
        dsp_mult_lane #(
            .A_W   (A_W),
            .B_W   (B_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .en_i  (vld_q[0]),
            .a_i   (a1_q[i*A_W +: A_W]),
            .b_i   (b1_q[i*B_W +: B_W]),
            .p_o   (prod[i])
        );
    end

    // S2 control travels alongside the products; S3 alongside the sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode2_q <= MODE_SUM;
            load2_q <= 1'b0;
            prev2_q <= '0;
            mode3_q <= MODE_SUM;
            load3_q <= 1'b0;
            prev3_q <= '0;
            sum3_q  <= '0;
        end else begin
            if (vld_q[0]) begin
                mode2_q <= mode1_q;
                load2_q <= load1_q;
                prev2_q <= prev1_q;
            end
            if (vld_q[1]) begin
                mode3_q <= mode2_q;
                load3_q <= load2_q;
                prev3_q <= prev2_q;
                sum3_q  <= tree[LVL][0];
            end
        end
    end

    // Balanced pairwise adder tree, padded with zeros to a power of two.
    for (genvar i = 0; i < NP2; i++) begin : g_leaf
        if (i < N_PAIRS) begin : g_used
            assign tree[0][i] = prod[i];
        end else begin : g_pad
            assign tree[0][i] = '0;
        end
    end
    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        for (genvar i = 0; i < NP2; i++) begin : g_node
            if (i < (NP2 >> (l + 1))) begin : g_add
                assign tree[l+1][i] = tree[l][2*i] + tree[l][2*i+1];
            end else begin : g_zero
                assign tree[l+1][i] = '0;
            end
        end
    end

    // S4: mode operation, overflow detection and optional clamping.
    always_comb begin
        acc_d     = acc_q;
        result_d  = result_q;
        to_next_d = to_next_q;
        ov_d      = ov_q;
        do_add    = 1'b0;
        add_a     = sum3_q;
        add_b     = '0;
        prev_ext  = ACC_W'($signed(prev3_q));

        case (mode3_q)
            MODE_ACC: begin
                if (!load3_q) begin
                    do_add = 1'b1;
                    add_a  = acc_q;
                    add_b  = sum3_q;
                end
            end
            MODE_CHAIN: begin
                do_add = 1'b1;
                add_a  = sum3_q;
                add_b  = prev_ext;
            end
            default: begin
                do_add = 1'b0;
            end
        endcase

        add_s   = add_a + add_b;
        add_ovf = do_add && (add_a[ACC_W-1] == add_b[ACC_W-1]) &&
                  (add_s[ACC_W-1] != add_a[ACC_W-1]);
        val     = do_add ? add_s : sum3_q;
`ifdef DSP_MAC_SATURATE_EN
        if (add_ovf) begin
            val = ACC_W'(sat_bound(ACC_W, add_a[ACC_W-1]));
        end
`endif

        if (vld_q[LAT-2]) begin
            result_d  = val;
            to_next_d = val[CHAIN_W-1:0];
            if (mode3_q == MODE_ACC) begin
                acc_d = val;
            end
            if ((mode3_q == MODE_ACC) && load3_q) begin
                ov_d = 1'b0;
            end else if (add_ovf) begin
                ov_d = 1'b1;
            end
        end
    end

    // S4 state: accumulator, result, cascade output and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            result_q  <= '0;
            to_next_q <= '0;
            ov_q      <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            result_q  <= result_d;
            to_next_q <= to_next_d;
            ov_q      <= ov_d;
        end
    end

    assign bus.out_valid = vld_q[LAT-1];
    assign bus.result    = result_q;
    assign bus.to_next   = to_next_q;
    assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// tb_dsp_mac_slice: directed vectors against an arithmetic model of the
// slice, plus hand-computed literal expectations.
module tb_dsp_mac_slice;
    import dsp_mac_pkg::*;

    localparam int unsigned A_W     = 8;
    localparam int unsigned B_W     = 8;
    localparam int unsigned N_PAIRS = 4;
    localparam int unsigned ACC_W   = 18;
    localparam int unsigned CHAIN_W = 12;

    localparam logic signed [63:0] MAXV     = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam logic signed [63:0] MINV     = -(64'sd1 <<< (ACC_W - 1));
    localparam logic [63:0]        MASK_ACC = (64'd1 << ACC_W) - 64'd1;
    localparam logic [63:0]        MASK_CH  = (64'd1 << CHAIN_W) - 64'd1;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        int                 due;
        logic signed [63:0] r;
        logic [63:0]        t;
        logic               o;
    } exp_t;

    exp_t               q[$];
    logic signed [63:0] m_acc;
    logic               m_ov;
    logic signed [63:0] hold_r;
    logic [63:0]        hold_t;
    logic               hold_o;
    logic               ev;

    dsp_mac_slice_if #(
        .A_W(A_W), .B_W(B_W), .N_PAIRS(N_PAIRS), .ACC_W(ACC_W), .CHAIN_W(CHAIN_W)
    ) bus ();

    dsp_mac_slice #(
        .A_W(A_W), .B_W(B_W), .N_PAIRS(N_PAIRS), .ACC_W(ACC_W), .CHAIN_W(CHAIN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, $signed(act), $signed(exp));
        end
    endtask

    // Out-of-range true sums either wrap or clamp; both set sticky overflow.
    function automatic logic signed [63:0] settle(input logic signed [63:0] t);
        logic signed [63:0] r;
        r = t;
        if (t > MAXV || t < MINV) begin
            m_ov = 1'b1;
`ifdef DSP_MAC_SATURATE_EN
            r = (t > MAXV) ? MAXV : MINV;
`else
            r = t & MASK_ACC;
            if (r > MAXV) r = r - (64'sd1 <<< ACC_W);
`endif
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_acc  = 0;
        m_ov   = 1'b0;
        hold_r = 0;
        hold_t = 0;
        hold_o = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat and record what the slice must produce DSP_MAC_LAT cycles later.
    task automatic beat(input mode_t m, input logic ld, input int a0, input int a1,
                        input int a2, input int a3, input int b0, input int b1,
                        input int b2, input int b3, input longint prev, output int due);
        int                 av[4];
        int                 bv[4];
        logic signed [63:0] s;
        logic signed [63:0] r;
        exp_t               e;
        av = '{a0, a1, a2, a3};
        bv = '{b0, b1, b2, b3};
        s  = 0;
        for (int k = 0; k < 4; k++) begin
            bus.a_bus[k*A_W +: A_W] = A_W'(av[k]);
            bus.b_bus[k*B_W +: B_W] = B_W'(bv[k]);
            s = s + 64'(av[k]) * 64'(bv[k]);
        end
        bus.in_valid      = 1'b1;
        bus.mode          = m;
        bus.acc_load      = ld;
        bus.from_previous = CHAIN_W'(prev);
        if (m == MODE_ACC && ld) begin
            m_acc = s;
            m_ov  = 1'b0;
            r     = s;
        end else if (m == MODE_ACC) begin
            r     = settle(m_acc + s);
            m_acc = r;
        end else if (m == MODE_CHAIN) begin
            r = settle(s + 64'(prev));
        end else begin
            r = s;
        end
        due = cyc + int'(DSP_MAC_LAT);
        e.due = due;
        e.r   = r;
        e.t   = r & MASK_CH;
        e.o   = m_ov;
        q.push_back(e);
        sync();
        bus.in_valid = 1'b0;
    endtask

    task automatic bubble();
        bus.in_valid = 1'b0;
        bus.a_bus    = '1;
        bus.b_bus    = '1;
        bus.mode     = MODE_ACC;
        bus.acc_load = 1'b0;
        sync();
    endtask

    task automatic wait_cyc(input int target, input string nm);
        while (cyc < target) @(negedge clk);
        if (cyc != target) chk({nm, "_late"}, 64'(cyc), 64'(target));
    endtask

    task automatic expect_at(input int due, input string nm, input longint er, input logic eo);
        wait_cyc(due, nm);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_result"}, 64'($signed(bus.result)), 64'(er));
        chk({nm, "_ovf"}, 64'(bus.overflow), 64'(eo));
    endtask

    task automatic expect_none(input int target, input string nm);
        wait_cyc(target, nm);
        chk({nm, "_novalid"}, 64'(bus.out_valid), 64'd0);
    endtask

    // Every-cycle comparison of the DUT against the model queue.
    always @(negedge clk) begin
        ev = 1'b0;
        if (q.size() != 0 && q[0].due == cyc) begin
            hold_r = q[0].r;
            hold_t = q[0].t;
            hold_o = q[0].o;
            ev     = 1'b1;
            void'(q.pop_front());
        end
        chk("cmp_out_valid", 64'(bus.out_valid), 64'(ev));
        chk("cmp_result", 64'($signed(bus.result)), hold_r);
        chk("cmp_to_next", 64'(bus.to_next), hold_t);
        chk("cmp_overflow", 64'(bus.overflow), 64'(hold_o));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
        $fatal(1);
    end

    initial begin
        int d0, d1, d2, d3;
        reset             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.a_bus         = '0;
        bus.b_bus         = '0;
        bus.mode          = MODE_SUM;
        bus.acc_load      = 1'b0;
        bus.from_previous = '0;
        model_reset();
        repeat (2) sync();
        reset = 1'b1;

        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_to_next", 64'(bus.to_next), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);

        // Single SUM beat: 12 - 14 - 5 + 0.
        beat(MODE_SUM, 1'b0, 3, -2, 5, 1, 4, 7, -1, 0, 0, d0);
        expect_none(d0 - 1, "sum_early");
        expect_at(d0, "sum_beat", -7, 1'b0);
        expect_none(d0 + 1, "sum_after");
        sync();

        // Accumulate with a bubble in the middle.
        beat(MODE_ACC, 1'b1, 2, 0, 0, 0, 5, 0, 0, 0, 0, d0);
        beat(MODE_ACC, 1'b0, 1, 0, 0, 0, 5, 0, 0, 0, 0, d1);
        bubble();
        beat(MODE_ACC, 1'b0, 4, 0, 0, 0, -5, 0, 0, 0, 0, d3);
        expect_at(d0, "acc_load", 10, 1'b0);
        expect_at(d1, "acc_add", 15, 1'b0);
        expect_none(d1 + 1, "acc_bubble");
        expect_at(d3, "acc_neg", -5, 1'b0);
        sync();

        // Cascade: products sum to 36, upstream -100.
        beat(MODE_CHAIN, 1'b0, 2, 3, 4, 1, 3, 2, 4, 8, -100, d0);
        expect_at(d0, "chain", -64, 1'b0);
        chk("chain_to_next", 64'(bus.to_next), 64'h0FC0);
        sync();

        // Back-to-back mode changes, each beat keeps its own mode.
        beat(MODE_SUM, 1'b0, 1, 0, 0, 0, 1, 0, 0, 0, 0, d0);
        beat(MODE_ACC, 1'b1, 1, 0, 0, 0, 2, 0, 0, 0, 0, d1);
        beat(MODE_SUM, 1'b0, 1, 0, 0, 0, 3, 0, 0, 0, 0, d2);
        beat(MODE_ACC, 1'b0, 1, 0, 0, 0, 4, 0, 0, 0, 0, d3);
        expect_at(d0, "mix_sum1", 1, 1'b0);
        expect_at(d1, "mix_load2", 2, 1'b0);
        expect_at(d2, "mix_sum3", 3, 1'b0);
        expect_at(d3, "mix_add4", 6, 1'b0);
        sync();

        // Drive acc to the signed maximum (65536 + 65281 + 254), then add 1.
        beat(MODE_ACC, 1'b1, -128, -128, -128, -128, -128, -128, -128, -128, 0, d0);
        beat(MODE_ACC, 1'b0, -128, -128, -128, 127, -128, -128, -128, 127, 0, d1);
        beat(MODE_ACC, 1'b0, 127, 0, 0, 0, 2, 0, 0, 0, 0, d2);
        beat(MODE_ACC, 1'b0, 1, 0, 0, 0, 1, 0, 0, 0, 0, d3);
        expect_at(d2, "ovf_max", 131071, 1'b0);
`ifdef DSP_MAC_SATURATE_EN
        expect_at(d3, "ovf_add", 131071, 1'b1);
`else
        expect_at(d3, "ovf_add", -131072, 1'b1);
`endif
        sync();
        beat(MODE_SUM, 1'b0, 1, 0, 0, 0, 5, 0, 0, 0, 0, d0);
        beat(MODE_ACC, 1'b1, 1, 0, 0, 0, 3, 0, 0, 0, 0, d1);
        expect_at(d0, "ovf_sticky", 5, 1'b1);
        expect_at(d1, "ovf_clear", 3, 1'b0);
        sync();

        // Reset with three beats in flight discards them and clears acc.
        beat(MODE_SUM, 1'b0, 1, 0, 0, 0, 9, 0, 0, 0, 0, d0);
        beat(MODE_ACC, 1'b0, 1, 0, 0, 0, 9, 0, 0, 0, 0, d1);
        beat(MODE_SUM, 1'b0, 1, 0, 0, 0, 9, 0, 0, 0, 0, d2);
        reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_result", 64'(bus.result), 64'd0);
        repeat (2) sync();
        reset = 1'b1;
        repeat (6) sync();
        chk("postrst_valid", 64'(bus.out_valid), 64'd0);
        beat(MODE_ACC, 1'b0, 1, 0, 0, 0, 5, 0, 0, 0, 0, d0);
        beat(MODE_ACC, 1'b1, 1, 0, 0, 0, 7, 0, 0, 0, 0, d1);
        expect_at(d0, "postrst_add", 5, 1'b0);
        expect_at(d1, "postrst_load", 7, 1'b0);
        repeat (4) sync();

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_mac_slice.md
Name: dsp_mac_slice

Overview:
- Parametrised successor of the dual-multiplier-pair DSP half-block: N_PAIRS signed multipliers feeding a registered adder tree and an accumulator with cascade chain-in/chain-out.
- Adds a valid-qualified pipeline, runtime mode select, accumulator load/clear, overflow detection and a registered chain output to the next slice.
- Tiles into DSP columns; slices cascade through from_previous/to_next.

Parameters:
- A_W, 18, signed width of each A operand
- B_W, 18, signed width of each B operand
- N_PAIRS, 4, number of multipliers; even, 2..8
- ACC_W, 64, accumulator/result width; must be at least A_W+B_W+clog2(N_PAIRS)
- CHAIN_W, 44, cascade width; must be at most ACC_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  qualifies a_bus, b_bus, mode, acc_load, from_previous this cycle
- a_bus  in  N_PAIRS*A_W  packed signed A operands, lane i at [i*A_W +: A_W]
- b_bus  in  N_PAIRS*B_W  packed signed B operands, same lane layout
- mode  in  2  00 SUM, 01 ACC, 10 CHAIN, 11 reserved (treated as SUM)
- acc_load  in  1  in ACC mode, load instead of add
- from_previous  in  CHAIN_W  signed cascade input from the upstream slice
- out_valid  out  1  result and to_next valid
- result  out  ACC_W  signed result
- to_next  out  CHAIN_W  registered low CHAIN_W bits of result
- overflow  out  1  sticky overflow flag

Behaviour:
- Reset (reset=0, asynchronous): all pipeline valids, accumulator, result, to_next and overflow are 0. Reset asserted mid-operation discards all in-flight data. The first in_valid is accepted on the first edge after release.
- Pipeline: fixed latency 4 cycles from an in_valid edge to out_valid. No backpressure; one operation per cycle sustained.
  - S1: register operands and control.
  - S2: N_PAIRS signed products, each sign-extended to ACC_W.
  - S3: balanced registered adder tree giving sum.
  - S4: mode operation into the result register.
- Mode, acc_load and from_previous are captured at S1 and travel with their data. Changing mode between beats affects only later beats.
- S4 operations:
  - SUM: result = sum.
  - ACC, acc_load=1: acc = sum.
  - ACC, acc_load=0: acc = acc + sum.
  - CHAIN: result = sum + sign-extended from_previous (captured at S1).
- In ACC mode result mirrors acc. The accumulator keeps its value across non-ACC beats and bubbles. A bubble (valid=0) leaves acc, result and to_next unchanged and drives out_valid=0.
- Overflow: signed overflow of any S4 addition sets overflow. It stays set until reset or an ACC beat with acc_load=1 clears it. Without saturation, results wrap modulo 2^ACC_W.
- to_next updates with result. Truncation to CHAIN_W does not flag overflow.

Optional Feature:
- Macro: DSP_MAC_SATURATE_EN.
- Defined: any S4 addition that overflows clamps result/acc to the signed maximum or minimum of ACC_W (by sign of the operands); overflow is still set.
- Undefined: wrap-around as above; no saturation logic is generated.

Decomposition:
- Package dsp_mac_pkg holds:
  - mode typedef/constants (MODE_SUM, MODE_ACC, MODE_CHAIN, MODE_RSVD)
  - latency constant DSP_MAC_LAT = 4
  - a function for signed saturation bounds
- Sub-module dsp_mult_lane: one registered signed A_W x B_W multiplier with sign-extension to ACC_W, instantiated N_PAIRS times.

Test Plan:
- Reset then a single SUM beat with lanes A={3,-2,5,1}, B={4,7,-1,0} -> out_valid exactly 4 cycles later, result=-7. A 0 must be driven on the reset edge mid-pipeline.
- ACC: load beat sum=10 (acc_load=1), then beats of sum 5, a bubble, then -20 -> results 10, 15, -5. out_valid=0 during the bubble cycle.
- CHAIN: from_previous=-100, products summing to 36 -> result=-64 and to_next=-64 (CHAIN_W bits).
- Back-to-back mode switch SUM, ACC (load), SUM, ACC (add) with sums 1, 2, 3, 4 -> results 1, 2, 3, 6; each result carries its own captured mode.
- Overflow: load acc=2^(ACC_W-1)-1, add sum 1 -> overflow=1. Result is -2^(ACC_W-1) without the macro and 2^(ACC_W-1)-1 with DSP_MAC_SATURATE_EN. A following load clears overflow.
- Reset asserted with 3 beats in flight -> no out_valid after release; acc=0; next load beat behaves as from clean reset.
